// File: rtl/spi_read_master.sv
// SPI mode-0 read master: opcode, optional 24-bit address, then N data bytes.
// Ports: cmd_* request handshake, rx_byte/rx_strobe data out, done, spi_* pins.
module spi_read_master #(
  parameter int unsigned DIV    = 2,
  parameter int unsigned CS_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic        addr_en,
  input  logic [15:0] len,
  output logic [7:0]  rx_byte,
  output logic        rx_strobe,
  output logic        done,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_do,
  input  logic        spi_di
);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR, DATA, HOLD, GAP
  } state_t;

  localparam int CW = 9;
  localparam logic [CW-1:0] HL = CW'(DIV - 1);
  localparam logic [CW-1:0] BL = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] GL = CW'(CS_GAP - 1);

  state_t state_q, state_d;

  logic          alive;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [15:0]   rem;
  logic [31:0]   tx;
  logic          addr_en_q;
  logic          sync1, sync2;
  logic [1:0]    smp_q, lst_q;
  logic [7:0]    rx_sh;

  logic accept, shifting;
  logic half_end, bit_end, gap_end;
  logic byte_end, samp;

  assign accept   = cmd_valid & cmd_ready;
  assign shifting = state_q inside {CMD, ADDR, DATA};
  assign half_end = cnt == HL;
  assign bit_end  = cnt == BL;
  assign gap_end  = cnt == GL;
  assign samp     = (state_q == DATA) && bit_end;
  assign byte_end = samp && (bit_cnt[2:0] == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (half_end) state_d = CMD;
      CMD:
        if (bit_end && bit_cnt == 5'd7) begin
          if (addr_en_q)       state_d = ADDR;
          else if (rem != '0)  state_d = DATA;
          else                 state_d = HOLD;
        end
      ADDR:
        if (bit_end && bit_cnt == 5'd23)
          state_d = (rem != '0) ? DATA : HOLD;
      DATA:  if (byte_end && rem == 16'd1) state_d = HOLD;
      HOLD:  if (half_end) state_d = GAP;
      GAP:   if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt restarts on every state change and at each bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive   <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      alive <= 1'b1;
      if (state_d != state_q || state_q == IDLE ||
          (shifting && bit_end))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state_d != state_q)
        bit_cnt <= '0;
      else if (shifting && bit_end)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      tx        <= '0;
      addr_en_q <= 1'b0;
    end else if (accept) begin
      rem       <= len;
      tx        <= {cmd, addr};
      addr_en_q <= addr_en;
    end else begin
      if (byte_end)
        rem <= rem - 1'b1;
      if ((state_q inside {CMD, ADDR}) && bit_end)
        tx <= {tx[30:0], 1'b0};
    end
  end

  // Sample strobes trail the synchroniser by two cycles so the
  // captured bit is the one present at the end of the high phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      smp_q     <= '0;
      lst_q     <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
    end else begin
      sync1     <= spi_di;
      sync2     <= sync1;
      smp_q     <= {smp_q[0], samp};
      lst_q     <= {lst_q[0], byte_end};
      rx_strobe <= smp_q[1] & lst_q[1];
      if (smp_q[1])
        rx_sh <= {rx_sh[6:0], sync2};
      if (smp_q[1] && lst_q[1])
        rx_byte <= {rx_sh[6:0], sync2};
    end
  end

  assign cmd_ready = alive && (state_q == IDLE);
  assign spi_cs    = !(state_q inside {SETUP, CMD, ADDR, DATA, HOLD});
  assign spi_clk   = shifting && (cnt > HL);
  assign spi_do    = (state_q inside {SETUP, CMD, ADDR}) && tx[31];
  assign done      = (state_q == GAP) && gap_end;

endmodule

// File: tb/tb_spi_read_master.sv
// Directed bench for spi_read_master: two instances (DIV=2 and DIV=1)
// each with a behavioural SPI flash responder and a bus monitor.
`timescale 1ns/1ps
module tb_spi_read_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_valid, a_ready, a_aen, a_strobe, a_done;
  logic        a_sclk, a_cs, a_do;
  logic        a_di = 1'b0;
  logic [7:0]  a_cmd, a_rx;
  logic [23:0] a_addr;
  logic [15:0] a_len;

  logic        b_valid, b_ready, b_aen, b_strobe, b_done;
  logic        b_sclk, b_cs, b_do;
  logic        b_di = 1'b0;
  logic [7:0]  b_cmd, b_rx;
  logic [23:0] b_addr;
  logic [15:0] b_len;

  spi_read_master #(.DIV(2), .CS_GAP(4)) u_a (
    .clk(clk), .reset(rst_n),
    .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd(a_cmd), .addr(a_addr), .addr_en(a_aen), .len(a_len),
    .rx_byte(a_rx), .rx_strobe(a_strobe), .done(a_done),
    .spi_clk(a_sclk), .spi_cs(a_cs), .spi_do(a_do), .spi_di(a_di)
  );

  spi_read_master #(.DIV(1), .CS_GAP(2)) u_b (
    .clk(clk), .reset(rst_n),
    .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd(b_cmd), .addr(b_addr), .addr_en(b_aen), .len(b_len),
    .rx_byte(b_rx), .rx_strobe(b_strobe), .done(b_done),
    .spi_clk(b_sclk), .spi_cs(b_cs), .spi_do(b_do), .spi_di(b_di)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // responders: after hdr falling edges, shift out resp bytes MSB first
  logic [7:0] a_resp [4];
  logic [7:0] b_resp [4];
  int a_hdr = 8;
  int b_hdr = 8;
  int a_fall = 0;
  int b_fall = 0;

  always @(negedge a_sclk or posedge a_cs) begin
    int k;
    if (a_cs) begin
      a_fall = 0;
      a_di = 1'b0;
    end else begin
      a_fall++;
      k = a_fall - a_hdr;
      if (k >= 0 && k < 32) a_di = a_resp[k/8][7-(k%8)];
      else a_di = 1'b0;
    end
  end

  always @(negedge b_sclk or posedge b_cs) begin
    int k;
    if (b_cs) begin
      b_fall = 0;
      b_di = 1'b0;
    end else begin
      b_fall++;
      k = b_fall - b_hdr;
      if (k >= 0 && k < 32) b_di = b_resp[k/8][7-(k%8)];
      else b_di = 1'b0;
    end
  end

  // monitors
  int a_cyc = 0, a_edges = 0, a_pbad = 0, a_nrx = 0, a_dones = 0;
  int a_acc = 0, a_run = 0, a_gap = 0, a_dcyc = 0, a_acyc = 0;
  int a_rise = -1;
  logic [63:0] a_mosi = '0;
  logic a_sclk_p = 1'b0;
  logic [7:0] a_rxq [$];

  always @(negedge clk) begin
    if (a_sclk && !a_sclk_p) begin
      a_edges++;
      a_mosi = {a_mosi[62:0], a_do};
      if (a_rise >= 0 && a_cyc - a_rise != 4) a_pbad++;
      a_rise = a_cyc;
    end
    if (a_cs) a_rise = -1;
    a_sclk_p = a_sclk;
    if (a_strobe) begin
      a_nrx++;
      a_rxq.push_back(a_rx);
    end
    a_run = a_cs ? a_run + 1 : 0;
    if (a_done) begin
      a_dones++;
      a_gap = a_run;
      a_dcyc = a_cyc;
    end
    if (a_valid && a_ready) begin
      a_acc++;
      a_acyc = a_cyc;
    end
    a_cyc++;
  end

  int b_cyc = 0, b_edges = 0, b_pbad = 0, b_nrx = 0, b_dones = 0;
  int b_acc = 0, b_rise = -1;
  logic [63:0] b_mosi = '0;
  logic b_sclk_p = 1'b0;
  logic [7:0] b_rxq [$];

  always @(negedge clk) begin
    if (b_sclk && !b_sclk_p) begin
      b_edges++;
      b_mosi = {b_mosi[62:0], b_do};
      if (b_rise >= 0 && b_cyc - b_rise != 2) b_pbad++;
      b_rise = b_cyc;
    end
    if (b_cs) b_rise = -1;
    b_sclk_p = b_sclk;
    if (b_strobe) begin
      b_nrx++;
      b_rxq.push_back(b_rx);
    end
    if (b_done) b_dones++;
    if (b_valid && b_ready) b_acc++;
    b_cyc++;
  end

  task automatic a_go(input logic [7:0] c, input logic [23:0] ad,
                      input logic en, input logic [15:0] n);
    int base;
    base = a_acc;
    a_cmd = c; a_addr = ad; a_aen = en; a_len = n;
    a_valid = 1'b1;
    for (int i = 0; i < 100 && a_acc == base; i++) step();
    a_valid = 1'b0;
    chk("a_accept", a_acc != base, 1);
    a_cmd = 8'h5A; a_addr = 24'hFFFFFF; a_aen = ~en; a_len = 16'hFFFF;
  endtask

  task automatic b_go(input logic [7:0] c, input logic [15:0] n);
    int base;
    base = b_acc;
    b_cmd = c; b_addr = '0; b_aen = 1'b0; b_len = n;
    b_valid = 1'b1;
    for (int i = 0; i < 100 && b_acc == base; i++) step();
    b_valid = 1'b0;
    chk("b_accept", b_acc != base, 1);
    b_len = 16'hFFFF;
  endtask

  task automatic a_wait(input int target);
    for (int i = 0; i < 3000 && a_dones < target; i++) step();
    chk("a_done_wait", a_dones >= target, 1);
  endtask

  task automatic b_wait(input int target);
    for (int i = 0; i < 3000 && b_dones < target; i++) step();
    chk("b_done_wait", b_dones >= target, 1);
  endtask

  int e0, r0, d0, p0, c0, d1c;

  initial begin
    rst_n = 1'b1;
    a_valid = 1'b0; a_cmd = '0; a_addr = '0; a_aen = 1'b0; a_len = '0;
    b_valid = 1'b0; b_cmd = '0; b_addr = '0; b_aen = 1'b0; b_len = '0;
    a_resp[0] = 8'hEF; a_resp[1] = 8'h40;
    a_resp[2] = 8'h18; a_resp[3] = 8'h00;
    b_resp[0] = 8'h3C; b_resp[1] = 8'hC3;
    b_resp[2] = 8'h00; b_resp[3] = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs", a_cs, 1);
    chk("rst_sclk", a_sclk, 0);
    chk("rst_do", a_do, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_strobe", a_strobe, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rx", a_rx, 8'h00);
    repeat (3) step();
    chk("rst_ready_held", a_ready, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", a_ready, 0);
    step();
    chk("ready_after_edge", a_ready, 1);
    chk("b_ready_after_edge", b_ready, 1);

    // JEDEC ID read, no address, 3 bytes
    a_hdr = 8;
    e0 = a_edges; r0 = a_nrx; d0 = a_dones; p0 = a_pbad;
    a_go(8'h9F, 24'h0, 1'b0, 16'd3);
    a_wait(d0 + 1);
    repeat (4) step();
    chk("t1_edges", a_edges - e0, 32);
    chk("t1_cmd_bits", a_mosi[31:24], 8'h9F);
    chk("t1_data_do", a_mosi[23:0], 24'h0);
    chk("t1_period", a_pbad - p0, 0);
    chk("t1_nrx", a_nrx - r0, 3);
    chk("t1_rx0", a_rxq.pop_front(), 8'hEF);
    chk("t1_rx1", a_rxq.pop_front(), 8'h40);
    chk("t1_rx2", a_rxq.pop_front(), 8'h18);
    chk("t1_dones", a_dones - d0, 1);

    // read with address, 1 byte
    a_hdr = 32; a_resp[0] = 8'hA5;
    e0 = a_edges; r0 = a_nrx; d0 = a_dones;
    a_go(8'h03, 24'h123456, 1'b1, 16'd1);
    a_wait(d0 + 1);
    repeat (4) step();
    chk("t2_edges", a_edges - e0, 40);
    chk("t2_hdr_bits", a_mosi[39:8], 32'h03123456);
    chk("t2_nrx", a_nrx - r0, 1);
    chk("t2_rx", a_rxq.pop_front(), 8'hA5);
    chk("t2_dones", a_dones - d0, 1);

    // opcode only
    e0 = a_edges; r0 = a_nrx; d0 = a_dones;
    a_go(8'h06, 24'h0, 1'b0, 16'd0);
    a_wait(d0 + 1);
    chk("t3_gap", a_gap, 4);
    step();
    chk("t3_ready", a_ready, 1);
    repeat (4) step();
    chk("t3_edges", a_edges - e0, 8);
    chk("t3_cmd_bits", a_mosi[7:0], 8'h06);
    chk("t3_nrx", a_nrx - r0, 0);
    chk("t3_dones", a_dones - d0, 1);

    // back-to-back with cmd_valid held
    e0 = a_edges; d0 = a_dones; c0 = a_acc;
    a_cmd = 8'h06; a_addr = '0; a_aen = 1'b0; a_len = '0;
    a_valid = 1'b1;
    a_wait(d0 + 1);
    d1c = a_dcyc;
    chk("t4_gap1", a_gap, 4);
    chk("t4_no_queue", a_acc - c0, 1);
    for (int i = 0; i < 50 && a_acc < c0 + 2; i++) step();
    a_valid = 1'b0;
    chk("t4_acc2", a_acc - c0, 2);
    chk("t4_acc_after_done", a_acyc - d1c, 1);
    a_wait(d0 + 2);
    repeat (4) step();
    chk("t4_gap2", a_gap, 4);
    chk("t4_edges", a_edges - e0, 16);
    chk("t4_dones", a_dones - d0, 2);

    // reset in the middle of the address phase
    a_hdr = 32;
    e0 = a_edges; r0 = a_nrx; d0 = a_dones;
    a_go(8'h03, 24'h123456, 1'b1, 16'd1);
    for (int i = 0; i < 500 && a_edges < e0 + 18; i++) step();
    chk("t5_reach_addr", a_edges - e0, 18);
    rst_n = 1'b0;
    #1;
    chk("t5_cs", a_cs, 1);
    chk("t5_sclk", a_sclk, 0);
    chk("t5_ready", a_ready, 0);
    repeat (6) step();
    chk("t5_no_done", a_dones - d0, 0);
    chk("t5_no_rx", a_nrx - r0, 0);
    rst_n = 1'b1;
    step();
    chk("t5_ready_rel", a_ready, 1);

    a_hdr = 8; a_resp[0] = 8'hEF;
    e0 = a_edges; r0 = a_nrx; d0 = a_dones;
    a_go(8'h9F, 24'h0, 1'b0, 16'd3);
    a_wait(d0 + 1);
    repeat (4) step();
    chk("t5_edges", a_edges - e0, 32);
    chk("t5_nrx", a_nrx - r0, 3);
    chk("t5_rx0", a_rxq.pop_front(), 8'hEF);
    chk("t5_rx1", a_rxq.pop_front(), 8'h40);
    chk("t5_rx2", a_rxq.pop_front(), 8'h18);
    chk("t5_dones", a_dones - d0, 1);

    // DIV=1 instance, 2 bytes
    e0 = b_edges; r0 = b_nrx; d0 = b_dones; p0 = b_pbad;
    b_go(8'h9F, 16'd2);
    b_wait(d0 + 1);
    repeat (4) step();
    chk("t6_edges", b_edges - e0, 24);
    chk("t6_cmd_bits", b_mosi[23:16], 8'h9F);
    chk("t6_period", b_pbad - p0, 0);
    chk("t6_nrx", b_nrx - r0, 2);
    chk("t6_rx0", b_rxq.pop_front(), 8'h3C);
    chk("t6_rx1", b_rxq.pop_front(), 8'hC3);
    chk("t6_dones", b_dones - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_read_master.md
SPI_READ_MASTER -- requirements
Module: spi_read_master

Interface
REQ-001 Parameter: DIV, default 2, system clk cycles per spi_clk half-period (legal 1..255).
REQ-002 Parameter: CS_GAP, default 4, minimum clk cycles spi_cs stays high between transactions (legal 1..255).
REQ-003 Port: clk  input  1  system clock; all logic on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: cmd_valid  input  1  request a transaction.
REQ-006 Port: cmd_ready  output  1  block idle, request accepted this cycle if cmd_valid.
REQ-007 Port: cmd  input  8  SPI opcode, sent MSB first.
REQ-008 Port: addr  input  24  address, sent MSB first.
REQ-009 Port: addr_en  input  1  1 = send 24-bit address after opcode.
REQ-010 Port: len  input  16  number of data bytes to read (0 = none).
REQ-011 Port: rx_byte  output  8  received data byte.
REQ-012 Port: rx_strobe  output  1  one-cycle pulse, rx_byte valid.
REQ-013 Port: done  output  1  one-cycle pulse at end of transaction.
REQ-014 Port: spi_clk  output  1  SPI clock, mode 0 (idle low).
REQ-015 Port: spi_cs  output  1  chip select, active low.
REQ-016 Port: spi_do  output  1  data to device (MOSI).
REQ-017 Port: spi_di  input  1  data from device (MISO); synchronised by two flops internally.

Function
REQ-018 States: IDLE, SETUP, CMD, ADDR, DATA, HOLD, GAP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready; cmd, addr, addr_en, len latched on accept.
REQ-020 On accept: next cycle spi_cs=0, state SETUP for DIV cycles with spi_clk=0, spi_do=cmd[7].
REQ-021 Each bit SHALL take 2*DIV cycles: spi_clk low DIV cycles, then high DIV cycles; spi_do changes only at start of low phase.
REQ-022 spi_di SHALL be sampled (post-synchroniser, compensating 2-cycle delay) at the last clk cycle of each high phase.
REQ-023 CMD: 8 bits; then ADDR (24 bits) if addr_en, else DATA if len>0, else HOLD.
REQ-024 ADDR: 24 bits; then DATA if len>0, else HOLD.
REQ-025 DATA: spi_do=0; 8*len bits shifted in MSB first; rx_strobe pulses the cycle after the 8th bit of each byte is sampled.
REQ-026 Byte counter 16 bits; len=16'hFFFF SHALL read 65535 bytes with no wrap.
REQ-027 HOLD: spi_clk=0, spi_cs=0 for DIV cycles; then spi_cs=1, state GAP.
REQ-028 GAP: spi_cs=1 for CS_GAP cycles; done pulses on the final GAP cycle; next cycle IDLE, cmd_ready=1.
REQ-029 cmd_valid outside IDLE SHALL be ignored; no queuing.
REQ-030 Latched inputs SHALL not be affected by input changes after accept.
REQ-031 Bit counters SHALL be sized for the 24-bit address phase; no overflow into adjacent phases.

Reset
REQ-032 reset=0 SHALL immediately force: state IDLE, spi_cs=1, spi_clk=0, spi_do=0, rx_strobe=0, done=0, rx_byte=0, cmd_ready=0 until first clk edge after release.
REQ-033 Reset mid-transaction SHALL abort with no done pulse and no further rx_strobe.
REQ-034 After reset release, cmd_ready=1 on first clk edge; no GAP enforced.

Verification
REQ-035 DIV=2, cmd=8'h9F, addr_en=0, len=3, device returns EF,40,18 -> spi_do shows 10011111, rx_byte sequence EF,40,18 with 3 rx_strobe, spi_clk period 4 clk, one done.
REQ-036 cmd=8'h03, addr=24'h123456, addr_en=1, len=1, device returns A5 -> 32 bits on spi_do match 03123456, rx_byte=A5, 40 spi_clk rising edges total.
REQ-037 cmd=8'h06, addr_en=0, len=0 -> exactly 8 spi_clk pulses, no rx_strobe, done once, spi_cs high >= CS_GAP cycles before cmd_ready.
REQ-038 Back-to-back: cmd_valid held high for two requests -> second accepted only after done, spi_cs high exactly CS_GAP cycles between.
REQ-039 Assert reset during ADDR bit 10 -> spi_cs=1 and spi_clk=0 same cycle, no done; after release a new 9F transaction completes normally.
REQ-040 DIV=1, len=2 -> spi_clk period 2 clk, data sampled correctly with synchroniser compensation.
